// File: rtl/uart_rx_frontend.sv
// ============================================================================
// Module      : uart_rx_frontend
// Description : 8N1 UART receiver with line synchroniser, mid-bit sampling,
//               framing-error detection and break handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rx_Serial_in,
    output logic              Rx_DV_out,
    output logic signed [7:0] Rx_Byte_out,
    output logic              Frame_Err_out,
    output logic              Busy_out
);

    localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_HALF = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [15:0]            r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   w_s;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign Busy_out = (r_state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync        <= '1;
            r_state       <= S_IDLE;
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            Rx_DV_out     <= 1'b0;
            Rx_Byte_out   <= '0;
            Frame_Err_out <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], Rx_Serial_in};
            Rx_DV_out     <= 1'b0;
            Frame_Err_out <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!w_s) begin
                        r_state <= S_START;
                    end
                end

                // Re-check the line half a bit in; a high level means a glitch.
                S_START: begin
                    if (r_clk_cnt == c_HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (r_clk_cnt == c_LAST) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                // Leaving at mid-stop lets a start bit that follows immediately be caught.
                S_STOP: begin
                    if (r_clk_cnt == c_LAST) begin
                        r_clk_cnt <= '0;
                        if (w_s) begin
                            Rx_Byte_out <= r_shift;
                            Rx_DV_out   <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            Frame_Err_out <= 1'b1;
                            r_state       <= S_BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                S_BREAK: begin
                    if (w_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
// Module      : tb_uart_rx_frontend
// Description : Self-checking bench for uart_rx_frontend against a frame-level
//               reference model (expected event cycle and byte per frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frontend;

    localparam int c_N   = 16;
    localparam int c_S   = 2;
    localparam int c_H   = (c_N - 1) / 2;
    // Edges from the driving edge of the start bit to the DV/error edge.
    localparam int c_LAT = 1 + c_S + c_H + 9 * c_N + 1;

    typedef struct {
        int         c;
        logic [7:0] b;
        logic       dv;
        logic       err;
    } ev_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              line  = 1'b1;
    logic              dv;
    logic              ferr;
    logic              busy;
    logic signed [7:0] byte_out;

    int         cyc       = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;
    logic [7:0] last_good = 8'h00;
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    uart_rx_frontend #(
        .CLKS_PER_BIT (c_N),
        .SYNC_STAGES  (c_S)
    ) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .Rx_Serial_in  (line),
        .Rx_DV_out     (dv),
        .Rx_Byte_out   (byte_out),
        .Frame_Err_out (ferr),
        .Busy_out      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv || ferr) obs_q.push_back('{cyc, byte_out, dv, ferr});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_q.push_back('{cyc + c_LAT, b, stop, !stop});
        if (stop) last_good = b;
        line = 1'b0;
        step(c_N);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            step(c_N);
        end
        line = stop;
        step(c_N);
        line = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        line  = 1'b1;
        step(3);
        n_checks += 4;
        if (dv !== 1'b0)       begin n_fail++; $display("FAIL reset_dv: got %0b, expected 0", dv); end
        if (byte_out !== 8'sh00) begin n_fail++; $display("FAIL reset_byte: got %02h, expected 00", byte_out); end
        if (ferr !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %0b, expected 0", ferr); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic test_good_frame;
        send_frame(8'hA5, 1'b1);
        step(3 * c_N);
        n_checks += 2;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL good_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].dv !== exp_q[i].dv || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].dv && obs_q[i].b !== exp_q[i].b)) begin
                n_fail++;
                $display("FAIL good_event[%0d]: got cyc=%0d dv=%0b err=%0b byte=%02h, expected cyc=%0d dv=%0b err=%0b byte=%02h",
                         i, obs_q[i].c, obs_q[i].dv, obs_q[i].err, obs_q[i].b, exp_q[i].c, exp_q[i].dv, exp_q[i].err, exp_q[i].b);
            end
        end
        if (byte_out !== last_good) begin n_fail++; $display("FAIL good_byte_hold: got %02h, expected %02h", byte_out, last_good); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frame_error;
        send_frame(8'h3C, 1'b0);
        step(3 * c_N);
        n_checks += 3;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL ferr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].dv !== exp_q[i].dv || obs_q[i].err !== exp_q[i].err) begin
                n_fail++;
                $display("FAIL ferr_event[%0d]: got cyc=%0d dv=%0b err=%0b, expected cyc=%0d dv=%0b err=%0b",
                         i, obs_q[i].c, obs_q[i].dv, obs_q[i].err, exp_q[i].c, exp_q[i].dv, exp_q[i].err);
            end
        end
        if (byte_out !== last_good) begin n_fail++; $display("FAIL ferr_byte_hold: got %02h, expected %02h", byte_out, last_good); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_after: got %0b, expected 0", busy); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch;
        line = 1'b0;
        step(3);
        line = 1'b1;
        n_checks += 3;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %0b, expected 1", busy); end
        step(3 * c_N);
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %0b, expected 0", busy); end
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch_events: got %0d events, expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFF, 1'b1);
        step(3 * c_N);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].dv !== exp_q[i].dv || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].dv && obs_q[i].b !== exp_q[i].b)) begin
                n_fail++;
                $display("FAIL b2b_event[%0d]: got cyc=%0d dv=%0b err=%0b byte=%02h, expected cyc=%0d dv=%0b err=%0b byte=%02h",
                         i, obs_q[i].c, obs_q[i].dv, obs_q[i].err, obs_q[i].b, exp_q[i].c, exp_q[i].dv, exp_q[i].err, exp_q[i].b);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_break;
        exp_q.push_back('{cyc + c_LAT, 8'h00, 1'b0, 1'b1});
        line = 1'b0;
        step(40 * c_N);
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_held: got %0b, expected 1", busy); end
        line = 1'b1;
        step(2 * c_N);
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_released: got %0b, expected 0", busy); end
        send_frame(8'h55, 1'b1);
        step(3 * c_N);
        n_checks += 2;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL break_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].dv !== exp_q[i].dv || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].dv && obs_q[i].b !== exp_q[i].b)) begin
                n_fail++;
                $display("FAIL break_event[%0d]: got cyc=%0d dv=%0b err=%0b byte=%02h, expected cyc=%0d dv=%0b err=%0b byte=%02h",
                         i, obs_q[i].c, obs_q[i].dv, obs_q[i].err, obs_q[i].b, exp_q[i].c, exp_q[i].dv, exp_q[i].err, exp_q[i].b);
            end
        end
        if (byte_out !== 8'sh55) begin n_fail++; $display("FAIL break_byte: got %02h, expected 55", byte_out); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        for (int f = 0; f < 14; f++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            step(stop ? $urandom_range(0, c_N) : $urandom_range(1, c_N));
        end
        step(3 * c_N);
        n_checks += 2;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].dv !== exp_q[i].dv || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].dv && obs_q[i].b !== exp_q[i].b)) begin
                n_fail++;
                $display("FAIL rand_event[%0d]: got cyc=%0d dv=%0b err=%0b byte=%02h, expected cyc=%0d dv=%0b err=%0b byte=%02h",
                         i, obs_q[i].c, obs_q[i].dv, obs_q[i].err, obs_q[i].b, exp_q[i].c, exp_q[i].dv, exp_q[i].err, exp_q[i].b);
            end
        end
        if (byte_out !== last_good) begin n_fail++; $display("FAIL rand_byte_hold: got %02h, expected %02h", byte_out, last_good); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b    = 8'h77;
        line = 1'b0;
        step(c_N);
        for (int i = 0; i < 3; i++) begin
            line = b[i];
            step(c_N);
        end
        rst_n = 1'b0;
        line  = 1'b1;
        step(2);
        last_good = 8'h00;
        n_checks += 4;
        if (dv !== 1'b0)         begin n_fail++; $display("FAIL midrst_dv: got %0b, expected 0", dv); end
        if (byte_out !== 8'sh00) begin n_fail++; $display("FAIL midrst_byte: got %02h, expected 00", byte_out); end
        if (ferr !== 1'b0)       begin n_fail++; $display("FAIL midrst_err: got %0b, expected 0", ferr); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_busy: got %0b, expected 0", busy); end
        rst_n = 1'b1;
        step(12 * c_N);
        n_checks += 2;
        if (obs_q.size() !== 0)  begin n_fail++; $display("FAIL midrst_events: got %0d events, expected 0", obs_q.size()); end
        if (byte_out !== last_good) begin n_fail++; $display("FAIL midrst_byte_after: got %02h, expected %02h", byte_out, last_good); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_break();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
